// File: rtl/shiftreg_rx_pkg.sv
// Shared definitions for the serial frame link (receive and transmit sides).
package shiftreg_rx_pkg;

  // Receiver state encoding, 2 bits.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam int unsigned START_BITS = 1;
  localparam int unsigned STOP_BITS  = 1;

  // Non-data bits per frame: start + stop + optional parity.
  function automatic int unsigned frame_overhead(input bit parity_en);
    return START_BITS + STOP_BITS + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/shiftreg_rx.sv
// Serial-in, parallel-out frame receiver.
// Frame on the line: start(0), WIDTH data bits, optional even parity, stop(1).
// Handshake: i_in is consumed only on cycles with i_in_vld=1; there is no
// back-pressure. o_data_vld / o_err are single-cycle pulses, mutually exclusive,
// registered one clock after the stop-bit sample.
module shiftreg_rx
  import shiftreg_rx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in,
  input  logic             i_in_vld,
  output logic [WIDTH-1:0] o_data,
  output logic             o_data_vld,
  output logic             o_err,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  rx_state_e        state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [WIDTH-1:0] shreg_q,    shreg_d;
  logic             par_q,      par_d;
  logic [WIDTH-1:0] data_q,     data_d;
  logic             data_vld_q, data_vld_d;
  logic             err_q,      err_d;
  logic             busy_q,     busy_d;
  logic             frame_good;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      data_q     <= '0;
      data_vld_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      data_q     <= data_d;
      data_vld_q <= data_vld_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: frame sequencing, shifting and stop-bit evaluation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    data_d     = data_q;
    data_vld_d = 1'b0;
    err_d      = 1'b0;
    // Even parity: data bits XOR parity bit must be zero.
    frame_good = i_in && (!PARITY_EN || ((^shreg_q) ^ par_q) == 1'b0);

    if (i_in_vld) begin
      case (state_q)
        ST_IDLE: begin
          // A high sample is just idle line; low is a start bit.
          if (!i_in) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], i_in};
          else           shreg_d = {i_in, shreg_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          par_d   = i_in;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          // A bad frame leaves o_data untouched.
          if (frame_good) begin
            data_d     = shreg_q;
            data_vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign o_data     = data_q;
  assign o_data_vld = data_vld_q;
  assign o_err      = err_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_shiftreg_rx.sv
// Bench for shiftreg_rx: three instances (MSB-first no parity, MSB-first with
// parity, LSB-first no parity), directed frames, one tagged expected queue.
module tb_shiftreg_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_s   [3];
  logic       vld_s  [3];
  logic [7:0] data_o [3];
  logic       dv_o   [3];
  logic       err_o  [3];
  logic       busy_o [3];

  // Expected entry: {dut index[1:0], is_err, data[7:0]}
  logic [10:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  shiftreg_rx #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_dut (
    .clk(clk), .rst(rst), .i_in(in_s[0]), .i_in_vld(vld_s[0]),
    .o_data(data_o[0]), .o_data_vld(dv_o[0]), .o_err(err_o[0]), .o_busy(busy_o[0]));

  shiftreg_rx #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_par (
    .clk(clk), .rst(rst), .i_in(in_s[1]), .i_in_vld(vld_s[1]),
    .o_data(data_o[1]), .o_data_vld(dv_o[1]), .o_err(err_o[1]), .o_busy(busy_o[1]));

  shiftreg_rx #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .i_in(in_s[2]), .i_in_vld(vld_s[2]),
    .o_data(data_o[2]), .o_data_vld(dv_o[2]), .o_err(err_o[2]), .o_busy(busy_o[2]));

  // Clock / reset
  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks: values set just after an edge are sampled on the next edge.
  task automatic cyc(input int d, input logic v, input logic b);
    @(posedge clk);
    #1;
    vld_s[d] = v;
    in_s[d]  = b;
  endtask

  task automatic exp_push(input int d, input logic e, input logic [7:0] data);
    exp_q.push_back({d[1:0], e, data});
  endtask

  // Sends start, 8 data bits (bits[7] first on the line), opt. parity, stop.
  task automatic send_frame(input int d, input logic [7:0] bits, input logic par_en,
                            input logic par, input logic stop, input int gap);
    logic [10:0] stream;
    int nb;
    stream = par_en ? {1'b0, bits, par, stop} : {1'b0, 1'b0, bits, stop};
    nb = par_en ? 11 : 10;
    for (int j = nb - 1; j >= 0; j--) begin
      cyc(d, 1'b1, stream[j]);
      for (int g = 0; g < gap; g++) cyc(d, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) cyc(d, 1'b0, 1'b1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [10:0] got, exp;
    for (int d = 0; d < 3; d++) begin
      if (dv_o[d] || err_o[d]) begin
        n_cmp++;
        if (dv_o[d] && err_o[d]) begin
          n_fail++;
          $display("FAIL both_pulses dut%0d: vld=1 err=1 expected exclusive @%0t", d, $time);
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out dut%0d: err=%0b data=0x%0h, none expected @%0t",
                   d, err_o[d], data_o[d], $time);
        end else begin
          got = {d[1:0], err_o[d], data_o[d]};
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL frame_out: got dut%0d err=%0b data=0x%0h expected dut%0d err=%0b data=0x%0h @%0t",
                     got[10:9], got[8], got[7:0], exp[10:9], exp[8], exp[7:0], $time);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [9:0] stream;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      vld_s[d] = 1'b0;
      in_s[d]  = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_data%0d", d), 32'(data_o[d]), 32'h0);
      chk($sformatf("reset_vld%0d", d),  32'(dv_o[d]),   32'h0);
      chk($sformatf("reset_err%0d", d),  32'(err_o[d]),  32'h0);
      chk($sformatf("reset_busy%0d", d), 32'(busy_o[d]), 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    idle(0, 2);

    // Case 1: continuous vld, 0,1,1,1,0,0,0,1,1,1 -> E3, busy from start to stop
    stream = 10'b0_1110_0011_1;
    exp_push(0, 1'b0, 8'hE3);
    for (int j = 0; j < 10; j++) begin
      cyc(0, 1'b1, stream[9-j]);
      @(negedge clk);
      chk($sformatf("busy_bit%0d", j), 32'(busy_o[0]), (j >= 1) ? 32'h1 : 32'h0);
    end
    cyc(0, 1'b0, 1'b1);
    @(negedge clk);
    chk("e3_vld_timing", 32'(dv_o[0]), 32'h1);
    chk("e3_data", 32'(data_o[0]), 32'hE3);
    chk("e3_busy_after", 32'(busy_o[0]), 32'h0);
    cyc(0, 1'b0, 1'b1);
    @(negedge clk);
    chk("e3_vld_one_cycle", 32'(dv_o[0]), 32'h0);

    // Case 2: vld every 3rd cycle, random gap values
    exp_push(0, 1'b0, 8'hE3);
    send_frame(0, 8'hE3, 1'b0, 1'b0, 1'b1, 2);
    idle(0, 3);

    // Case 3: bad stop bit on A5, o_data holds E3
    exp_push(0, 1'b1, 8'hE3);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
    cyc(0, 1'b0, 1'b1);
    @(negedge clk);
    chk("bad_stop_err", 32'(err_o[0]), 32'h1);
    chk("bad_stop_hold", 32'(data_o[0]), 32'hE3);
    chk("bad_stop_idle", 32'(busy_o[0]), 32'h0);
    idle(0, 2);
    @(negedge clk);
    chk("err_one_cycle", 32'(err_o[0]), 32'h0);

    // Case 4: reset after 4th data bit of 3C, then 81
    cyc(0, 1'b1, 1'b0);
    cyc(0, 1'b1, 1'b0);
    cyc(0, 1'b1, 1'b0);
    cyc(0, 1'b1, 1'b1);
    cyc(0, 1'b1, 1'b1);
    cyc(0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_data", 32'(data_o[0]), 32'h0);
    chk("rst_mid_busy", 32'(busy_o[0]), 32'h0);
    chk("rst_mid_err",  32'(err_o[0]),  32'h0);
    chk("rst_mid_vld",  32'(dv_o[0]),   32'h0);
    exp_push(0, 1'b0, 8'h81);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 0);
    idle(0, 2);

    // Case 5: back-to-back 55, AA
    exp_push(0, 1'b0, 8'h55);
    exp_push(0, 1'b0, 8'hAA);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 0);
    send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1, 0);
    idle(0, 3);

    // Case 6: parity instance, 0F with good then bad parity
    exp_push(1, 1'b0, 8'h0F);
    send_frame(1, 8'h0F, 1'b1, 1'b0, 1'b1, 0);
    idle(1, 2);
    exp_push(1, 1'b1, 8'h0F);
    send_frame(1, 8'h0F, 1'b1, 1'b1, 1'b1, 0);
    idle(1, 3);

    // Case 7: LSB-first with the case-1 stream -> C7
    exp_push(2, 1'b0, 8'hC7);
    send_frame(2, 8'hE3, 1'b0, 1'b0, 1'b1, 0);
    idle(2, 3);

    // Bounded drain of outstanding expectations
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
    chk("final_data0", 32'(data_o[0]), 32'hAA);
    chk("final_data1", 32'(data_o[1]), 32'h0F);
    chk("final_data2", 32'(data_o[2]), 32'hC7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
